// File: rtl/pattern_scan_unit.sv
// pattern_scan_unit
//   Reads NBYTES bytes from a synchronous data memory, starting at BASE_ADDR,
//   and counts occurrences of a masked PAT_W-bit pattern three ways:
//     cnt_inbyte - matching windows lying wholly inside one byte
//     cnt_bytes  - bytes holding at least one in-byte match
//     cnt_cross  - matches over the continuous bit stream (byte 0 first,
//                  bit 7 first), so windows spanning byte boundaries count too
//   All windows of a byte are evaluated in parallel in the cycle its data
//   returns. Every counter saturates instead of wrapping.
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   start              : run request, only looked at in IDLE
//   pat, mask          : pattern and per-bit compare enable, captured at start
//   rd_en, rd_addr     : memory read strobe and address
//   rd_data            : memory data, valid the cycle after rd_en
//   cnt_inbyte/bytes/cross : result counters, held after done
//   busy, done         : run in progress / one-cycle completion pulse
module pattern_scan_unit #(
  parameter int PAT_W     = 5,
  parameter int NBYTES    = 32,
  parameter int CNT_W     = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [PAT_W-1:0] mask,
  output logic             rd_en,
  output logic [7:0]       rd_addr,
  input  logic [7:0]       rd_data,
  output logic [CNT_W-1:0] cnt_inbyte,
  output logic [CNT_W-1:0] cnt_bytes,
  output logic [CNT_W-1:0] cnt_cross,
  output logic             busy,
  output logic             done
);

  localparam int NIN = 9 - PAT_W;  // windows wholly inside a byte
  localparam int HW  = PAT_W - 1;  // stream history bits carried between bytes
  localparam logic [7:0] BASE = BASE_ADDR[7:0];
  localparam logic [7:0] LAST = 8'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       idx_reg;
  logic [7:0]       addr_reg;
  logic [PAT_W-1:0] pat_reg, mask_reg;
  logic [HW-1:0]    hist_reg;
  logic             valid_reg;   // rd_data holds a byte of this run
  logic             first_reg;   // next accumulated byte is byte 0
  logic [CNT_W-1:0] cnt_inbyte_reg, cnt_bytes_reg, cnt_cross_reg;

  // Stream view: older history bits above the new byte. Window gi covers
  // ext[gi+PAT_W-1:gi]; windows gi < NIN touch only rd_data.
  logic [HW+7:0] ext;
  logic [7:0]    x_hit;
  logic [3:0]    n_in, n_x, inc_cross;

  assign ext = {hist_reg, rd_data};

  for (genvar gi = 0; gi < 8; gi++) begin : g_win
    assign x_hit[gi] = ((ext[gi +: PAT_W] ^ pat_reg) & mask_reg) == '0;
  end

  always_comb begin
    n_in = '0;
    n_x  = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < NIN && x_hit[i]) n_in = n_in + 4'd1;
      if (x_hit[i])            n_x  = n_x + 4'd1;
    end
    // Byte 0 has no predecessor, so only its in-byte windows are real.
    inc_cross = first_reg ? n_in : n_x;
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0] b);
    logic [CNT_W+3:0] s;
    s = {4'b0, a} + {{CNT_W{1'b0}}, b};
    if (s > {4'b0, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (idx_reg == LAST) state_next = DRAIN;
      DRAIN:   state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg        <= '0;
      addr_reg       <= BASE;
      pat_reg        <= '0;
      mask_reg       <= '0;
      hist_reg       <= '0;
      valid_reg      <= 1'b0;
      first_reg      <= 1'b0;
      cnt_inbyte_reg <= '0;
      cnt_bytes_reg  <= '0;
      cnt_cross_reg  <= '0;
    end else begin
      valid_reg <= (state_reg == FETCH);
      case (state_reg)
        IDLE: if (start) begin
          pat_reg        <= pat;
          mask_reg       <= mask;
          idx_reg        <= '0;
          addr_reg       <= BASE;
          hist_reg       <= '0;
          first_reg      <= 1'b1;
          cnt_inbyte_reg <= '0;
          cnt_bytes_reg  <= '0;
          cnt_cross_reg  <= '0;
        end
        FETCH: if (idx_reg != LAST) begin
          idx_reg  <= idx_reg + 8'd1;
          addr_reg <= addr_reg + 8'd1;
        end
        default: ;
      endcase
      // valid_reg is never set in IDLE, so this cannot collide with the clear.
      if (valid_reg) begin
        cnt_inbyte_reg <= sat_add(cnt_inbyte_reg, n_in);
        cnt_bytes_reg  <= sat_add(cnt_bytes_reg, {3'b0, |x_hit[NIN-1:0]});
        cnt_cross_reg  <= sat_add(cnt_cross_reg, inc_cross);
        hist_reg       <= rd_data[HW-1:0];
        first_reg      <= 1'b0;
      end
    end
  end

  assign rd_en      = (state_reg == FETCH);
  assign rd_addr    = addr_reg;
  assign busy       = (state_reg == FETCH) || (state_reg == DRAIN);
  assign done       = (state_reg == FINISH);
  assign cnt_inbyte = cnt_inbyte_reg;
  assign cnt_bytes  = cnt_bytes_reg;
  assign cnt_cross  = cnt_cross_reg;

endmodule

// File: tb/tb_pattern_scan_unit.sv
// Directed bench for pattern_scan_unit: a table of memory fills and patterns
// with hand-computed counts on a default-parameter instance, plus reset-abort,
// mid-run disturbance and a saturating PAT_W=2 / NBYTES=40 instance.
module tb_pattern_scan_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start2;
  logic [4:0] pat, mask;
  logic [1:0] pat2, mask2;
  logic       rd_en, rd_en2, busy, busy2, done, done2;
  logic [7:0] rd_addr, rd_addr2;
  logic [7:0] rd_data = 8'h00, rd_data2 = 8'h00;
  logic [7:0] cnt_inbyte, cnt_bytes, cnt_cross;
  logic [7:0] cnt_inbyte2, cnt_bytes2, cnt_cross2;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) if (rd_en2) rd_data2 <= 8'hFF;

  pattern_scan_unit dut (
    .clk(clk), .reset(reset), .start(start), .pat(pat), .mask(mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cnt_inbyte(cnt_inbyte), .cnt_bytes(cnt_bytes), .cnt_cross(cnt_cross),
    .busy(busy), .done(done)
  );

  pattern_scan_unit #(.PAT_W(2), .NBYTES(40)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pat(pat2), .mask(mask2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .cnt_inbyte(cnt_inbyte2), .cnt_bytes(cnt_bytes2), .cnt_cross(cnt_cross2),
    .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic fill(input logic [7:0] b0, b1, rest);
    for (int i = 0; i < 256; i++) mem[i] = rest;
    mem[0] = b0;
    mem[1] = b1;
  endtask

  // One run on dut: 60 cycles after acceptance, counting rd_en cycles and
  // done pulses. With disturb set, start is re-pulsed and pat/mask are
  // scrambled mid-run; the run must ignore both.
  task automatic run_scan(input string tag, input logic [4:0] p, m,
                          input bit disturb);
    int nrd, ndone, done_at;
    nrd = 0; ndone = 0; done_at = -1;
    @(negedge clk);
    start = 1'b1; pat = p; mask = m;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == 0) check({tag, " busy after accept"}, int'(busy), 1);
      if (rd_en) nrd++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
        check({tag, " busy low with done"}, int'(busy), 0);
      end
      if (disturb && n == 5) begin start = 1'b1; pat = ~p; mask = 5'b11111; end
      if (disturb && n == 6) begin start = 1'b0; end
    end
    check({tag, " rd_en cycles"}, nrd, 32);
    check({tag, " done pulses"}, ndone, 1);
    check({tag, " done cycle"}, done_at, 33);
  endtask

  typedef struct {
    logic [7:0] b0, b1, rest;
    logic [4:0] p, m;
    int e_in, e_by, e_cr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int nd;
    bit found;
    vecs[0] = '{8'h55, 8'h55, 8'h55, 5'b10101, 5'b11111, 64, 32, 126};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 5'b11111, 5'b11111, 128, 32, 252};
    vecs[2] = '{8'hA5, 8'h3C, 8'h96, 5'b10110, 5'b00000, 128, 32, 252};
    vecs[3] = '{8'h01, 8'h80, 8'h00, 5'b00011, 5'b11111, 0, 0, 1};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 5'b11111, 5'b11111, 0, 0, 0};
    vecs[5] = '{8'h1F, 8'h00, 8'h00, 5'b11111, 5'b11111, 1, 1, 1};
    vecs[6] = '{8'h00, 8'hF8, 8'h00, 5'b11111, 5'b11111, 1, 1, 1};
    vecs[7] = '{8'h55, 8'h55, 8'h55, 5'b00001, 5'b00011, 64, 32, 126};
    vecs[8] = '{8'h0F, 8'h0F, 8'h0F, 5'b00011, 5'b11111, 32, 32, 32};

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    pat = '0; mask = '0; pat2 = '0; mask2 = '0;
    fill(8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_en", int'(rd_en), 0);
    check("reset rd_addr", int'(rd_addr), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset cnt_cross", int'(cnt_cross), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      fill(vecs[i].b0, vecs[i].b1, vecs[i].rest);
      run_scan(t, vecs[i].p, vecs[i].m, 1'b0);
      check({t, " cnt_inbyte"}, int'(cnt_inbyte), vecs[i].e_in);
      check({t, " cnt_bytes"}, int'(cnt_bytes), vecs[i].e_by);
      check({t, " cnt_cross"}, int'(cnt_cross), vecs[i].e_cr);
    end

    // Mid-run start pulse and pattern change must not affect the run.
    fill(8'h55, 8'h55, 8'h55);
    run_scan("disturb", 5'b10101, 5'b11111, 1'b1);
    check("disturb cnt_inbyte", int'(cnt_inbyte), 64);
    check("disturb cnt_bytes", int'(cnt_bytes), 32);
    check("disturb cnt_cross", int'(cnt_cross), 126);

    // Reset while fetching address 10 aborts the run with no done pulse.
    @(negedge clk);
    start = 1'b1; pat = 5'b10101; mask = 5'b11111;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (rd_en && rd_addr == 8'd10) found = 1'b1;
    end
    check("abort reached addr 10", int'(found), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort rd_en", int'(rd_en), 0);
    check("abort busy", int'(busy), 0);
    check("abort cnt_inbyte", int'(cnt_inbyte), 0);
    check("abort cnt_cross", int'(cnt_cross), 0);
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (done) nd++; end
    check("abort no done", nd, 0);
    run_scan("after abort", 5'b10101, 5'b11111, 1'b0);
    check("after abort cnt_inbyte", int'(cnt_inbyte), 64);
    check("after abort cnt_cross", int'(cnt_cross), 126);

    // PAT_W=2, 40 bytes of 0xFF: in-byte and cross counts saturate.
    @(negedge clk);
    start2 = 1'b1; pat2 = 2'b11; mask2 = 2'b11;
    @(posedge clk); #1;
    start2 = 1'b0;
    nd = 0;
    repeat (60) begin @(posedge clk); #1; if (done2) nd++; end
    check("sat done pulses", nd, 1);
    check("sat cnt_inbyte", int'(cnt_inbyte2), 255);
    check("sat cnt_bytes", int'(cnt_bytes2), 40);
    check("sat cnt_cross", int'(cnt_cross2), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
